// File: rtl/decode_hazard_ctrl_if.sv
// Fetch/Decode issue handshake and writeback request bundle for decode_hazard_ctrl.
// The environment drives through master; the controller sits on slave.
interface decode_hazard_ctrl_if #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   inst_valid;
  logic [31:0]            instruction;
  logic                   dec_enable;
  logic                   stall;
  logic                   flush;

  logic                   alu_wb_req;
  logic [REG_W-1:0]       alu_wb_dst;
  logic [DATA_W-1:0]      alu_wb_data;
  logic                   alu_wb_gnt;

  logic                   mem_wb_req;
  logic [REG_W-1:0]       mem_wb_dst;
  logic [DATA_W-1:0]      mem_wb_data;
  logic                   mem_wb_gnt;

  logic                   rf_we;
  logic [REG_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [NUM_REGS-1:0]    pending;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output inst_valid, instruction, flush,
    output alu_wb_req, alu_wb_dst, alu_wb_data,
    output mem_wb_req, mem_wb_dst, mem_wb_data,
    input  dec_enable, stall, alu_wb_gnt, mem_wb_gnt,
    input  rf_we, rf_waddr, rf_wdata, pending, stall_cnt
  );

  modport slave (
    input  inst_valid, instruction, flush,
    input  alu_wb_req, alu_wb_dst, alu_wb_data,
    input  mem_wb_req, mem_wb_dst, mem_wb_data,
    output dec_enable, stall, alu_wb_gnt, mem_wb_gnt,
    output rf_we, rf_waddr, rf_wdata, pending, stall_cnt
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode issue controller: pending-write scoreboard with RAW/WAW blocking, round-robin
// arbitration of the single register-file write port, and a saturating stall counter.
module decode_hazard_ctrl #(
  parameter int         NUM_REGS    = 32,
  parameter logic [6:0] OPC_STORE   = 7'd35,
  parameter logic [6:0] OPC_BRANCH  = 7'd48,
  parameter logic [6:0] OPC_NOP     = 7'd0,
  parameter int         STALL_CNT_W = 16,
  parameter int         DATA_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_hazard_ctrl_if.slave bus
);
  localparam int   REG_W    = $clog2(NUM_REGS);
  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_MEM = 1'b1;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [6:0]       opcode;
  logic [REG_W-1:0] dst, src1, src2;
  logic             unused_inst_bits;

  assign opcode           = bus.instruction[31:25];
  assign dst              = bus.instruction[24:20];
  assign src1             = bus.instruction[19:15];
  assign src2             = bus.instruction[14:10];
  assign unused_inst_bits = ^bus.instruction[9:0];

  logic [NUM_REGS-1:0]    pending_q, pending_d;
  logic                   rf_we_q, rf_we_d;
  logic [REG_W-1:0]       rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]      rf_wdata_q, rf_wdata_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   last_gnt_q, last_gnt_d;

  logic writes_dst, hazard, issue, stall;
  logic alu_gnt, mem_gnt;

  assign writes_dst = (opcode != OPC_STORE) && (opcode != OPC_BRANCH) && (opcode != OPC_NOP);
  assign hazard     = pending_q[src1] | pending_q[src2] | (writes_dst & pending_q[dst]);

  // Issue outputs are forced low while reset is asserted, not just after the next edge.
  assign issue = rst_n & bus.inst_valid & ~hazard & ~bus.flush;
  assign stall = rst_n & bus.inst_valid & ~issue;

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (rst_n) begin
      if (bus.alu_wb_req && bus.mem_wb_req) begin
        if (last_gnt_q == LAST_MEM) alu_gnt = 1'b1;
        else                        mem_gnt = 1'b1;
      end else if (bus.alu_wb_req) begin
        alu_gnt = 1'b1;
      end else if (bus.mem_wb_req) begin
        mem_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    rf_we_d    = alu_gnt | mem_gnt;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_gnt) begin
      last_gnt_d = LAST_ALU;
      rf_waddr_d = bus.alu_wb_dst;
      rf_wdata_d = bus.alu_wb_data;
    end else if (mem_gnt) begin
      last_gnt_d = LAST_MEM;
      rf_waddr_d = bus.mem_wb_dst;
      rf_wdata_d = bus.mem_wb_data;
    end
  end

  // The clear is applied before the set so a same-edge set on that register wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q)                pending_d[rf_waddr_q] = 1'b0;
    if (issue && writes_dst)    pending_d[dst]        = 1'b1;
    if (bus.flush)              pending_d             = '0;
  end

  assign stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      stall_cnt_q <= '0;
      last_gnt_q  <= LAST_MEM;
    end else begin
      pending_q   <= pending_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_cnt_q <= stall_cnt_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign bus.dec_enable = issue;
  assign bus.stall      = stall;
  assign bus.alu_wb_gnt = alu_gnt;
  assign bus.mem_wb_gnt = mem_gnt;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pending    = pending_q;
  assign bus.stall_cnt  = stall_cnt_q;
endmodule
